mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Multi-cycle MIPS main controller.
- Registered FSM that sequences fetch, decode, execute, memory and writeback across several cycles per instruction.
- Drives the datapath muxes, register-file and memory strobes, and PC update.
- Supports a memory ready handshake and a retired-instruction counter.
- Replaces the single-cycle opcode decoder in the multi-cycle datapath.

Parameters:
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = memory always completes in one cycle (mem_ready ignored).
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instr[31:26], taken from the IR; stable after FETCH.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  writeback data select: 1 = MDR, 0 = ALUOut.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- alu_op  out  2  ALU op: 00 = add, 01 = sub, 10 = funct.
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding, for debug.
- instr_done  out  1  one-cycle pulse on the final cycle of an instruction.
- retired_count  out  RETIRE_W  instructions completed.

Behaviour:
- State register and retired_count are the only flops.
- All other outputs are decoded from state, plus mem_ready where noted.
- Any output not listed for a state is 0.

States (encoding: next state):
- 0 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write = pc_write = mem_ready (forced to 1 when MEM_HANDSHAKE=0). Advances to DECODE only on ready; otherwise holds.
- 1 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC
  - anything else -> illegal handling (see Optional Feature)
- 2 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_READ; sw -> MEM_WRITE.
- 3 MEM_READ: mem_read=1, i_or_d=1. Holds until ready, then -> MEM_WB.
- 4 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. -> FETCH.
- 5 MEM_WRITE: mem_write=1, i_or_d=1. Holds until ready, then -> FETCH.
- 6 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. -> R_WB.
- 7 R_WB: reg_write=1, reg_dst=1. -> FETCH.
- 8 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. -> FETCH.
- 9 JUMP: pc_write=1, pc_source=10. -> FETCH.
- 10 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. -> ADDI_WB.
- 11 ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
- Unused encodings -> FETCH.

instr_done and retired_count:
- instr_done=1 in any cycle whose next state is FETCH and the current state is not FETCH. For MEM_WRITE this means only the ready cycle.
- retired_count increments on instr_done and wraps at 2^RETIRE_W to 0.

Latencies with no memory stalls:
- R-type and addi: 4 cycles.
- lw: 5 cycles.
- sw: 4 cycles.
- beq and j: 3 cycles.
- Each cycle mem_ready is low adds one cycle.

Reset:
- rst asserted at any time (including mid-instruction or mid-stall) forces state=FETCH and retired_count=0 immediately.
- While in reset, outputs show FETCH decode with ir_write=pc_write gated by mem_ready; mem_write=0 and reg_write=0 are guaranteed.

Optional Feature:
- Macro: MIPS_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised opcode in DECODE -> state 12 TRAP.
  - TRAP asserts output illegal_op=1 (extra 1-bit port, present only when defined).
  - TRAP asserts no strobes and remains until reset.
  - instr_done is not pulsed.
- Undefined:
  - An unrecognised opcode in DECODE -> FETCH as a NOP.
  - instr_done pulses in that DECODE cycle and retired_count increments.
  - No illegal_op port.

Test Plan:
- Reset, then R-type with mem_ready=1 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; instr_done pulses once; retired_count=1.
- lw with mem_ready held low 3 cycles in MEM_READ -> state 3 held 4 cycles with mem_read=1, i_or_d=1; then MEM_WB with mem_to_reg=1; total 8 cycles.
- sw, beq, j, addi back-to-back with ready=1 -> 4+3+3+4 = 14 cycles; pc_write_cond=1 only in BRANCH; pc_source=10 in JUMP; retired_count=4.
- FETCH with mem_ready=0 for 2 cycles -> ir_write=0 and pc_write=0 while waiting; the IR load pulse lands on the ready cycle only.
- rst asserted mid-MEM_WRITE -> state=0 asynchronously; mem_write drops to 0 immediately; retired_count=0.
- Opcode 111111 -> with MIPS_CTRL_ILLEGAL_TRAP_EN: state 12, illegal_op=1, stuck until rst. Without: returns to FETCH after DECODE, instr_done pulses.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS controller (master) and its datapath (slave).
// Carries illegal_op only when MIPS_CTRL_ILLEGAL_TRAP_EN is defined.
interface mips_multicycle_control_if #(
  parameter int RETIRE_W = 32
);
  logic [5:0]          opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_source;
  logic [3:0]          state;
  logic                instr_done;
  logic [RETIRE_W-1:0] retired_count;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  logic                illegal_op;
`endif

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, instr_done, retired_count
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    , output illegal_op
`endif
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, instr_done, retired_count
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    , input illegal_op
`endif
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main controller: state register plus retired counter, outputs decoded from state.
// Optional MIPS_CTRL_ILLEGAL_TRAP_EN parks unknown opcodes in TRAP instead of treating them as NOPs.
module mips_multicycle_control #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int RETIRE_W      = 32
) (
  input logic clk,
  input logic rst,
  mips_multicycle_control_if.master ctl
);
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t state_q, state_d;
  logic   rdy;
  logic   done;

  // With the handshake disabled every memory access completes in a single cycle.
  assign rdy = MEM_HANDSHAKE ? ctl.mem_ready : 1'b1;

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:     state_d = rdy ? DECODE : FETCH;
      DECODE: begin
        case (ctl.opcode)
          OP_R:         state_d = R_EXEC;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EXEC;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEM_ADDR:  state_d = (ctl.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  state_d = rdy ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = rdy ? FETCH : MEM_WRITE;
      R_EXEC:    state_d = R_WB;
      ADDI_EXEC: state_d = ADDI_WB;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      TRAP:      state_d = TRAP;
`endif
      default:   state_d = FETCH;
    endcase
  end

  // Retirement is "leaving for FETCH from anywhere else"; a trap never retires.
  assign done = (state_d == FETCH) && (state_q != FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= FETCH;
      ctl.retired_count <= '0;
    end else begin
      state_q <= state_d;
      if (done) ctl.retired_count <= ctl.retired_count + 1'b1;
    end
  end

  always_comb begin
    ctl.pc_write      = 1'b0;
    ctl.pc_write_cond = 1'b0;
    ctl.i_or_d        = 1'b0;
    ctl.mem_read      = 1'b0;
    ctl.mem_write     = 1'b0;
    ctl.ir_write      = 1'b0;
    ctl.mem_to_reg    = 1'b0;
    ctl.reg_dst       = 1'b0;
    ctl.reg_write     = 1'b0;
    ctl.alu_src_a     = 1'b0;
    ctl.alu_src_b     = 2'b00;
    ctl.alu_op        = 2'b00;
    ctl.pc_source     = 2'b00;
    case (state_q)
      FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.ir_write  = rdy;
        ctl.pc_write  = rdy;
      end
      DECODE:    ctl.alu_src_b = 2'b11;
      MEM_ADDR, ADDI_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
      end
      MEM_READ: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
      end
      R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
      end
      R_WB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = 2'b01;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
      end
      JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = 2'b10;
      end
      ADDI_WB:   ctl.reg_write = 1'b1;
      default: ;
    endcase
  end

  assign ctl.state      = state_q;
  assign ctl.instr_done = done;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  assign ctl.illegal_op = (state_q == TRAP);
`endif
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: per-cycle state, strobe vector, instr_done and retire count.
// Strobe vector order: pcw pcwc iod mr mw irw m2r rdst rw asa asb[1:0] aop[1:0] psrc[1:0].
module tb_mips_multicycle_control;
  localparam int RW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  mips_multicycle_control_if #(.RETIRE_W(RW)) bus ();

  mips_multicycle_control #(.MEM_HANDSHAKE(1'b1), .RETIRE_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus.master)
  );

  always #5 clk = ~clk;

  logic [15:0] ctl_vec;
  assign ctl_vec = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                    bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                    bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                    bus.pc_source};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand-derived strobe vectors for each state with mem_ready=1.
  function automatic logic [15:0] exp_vec(input int s);
    case (s)
      0:       return 16'h9410;
      1:       return 16'h0030;
      2, 10:   return 16'h0060;
      3:       return 16'h3000;
      4:       return 16'h0280;
      5:       return 16'h2800;
      6:       return 16'h0048;
      7:       return 16'h0180;
      8:       return 16'h4045;
      9:       return 16'h8002;
      11:      return 16'h0080;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the current cycle, then advance one clock.
  task automatic step(input int s, input bit done);
    logic [15:0] e;
    #1;
    e = exp_vec(s);
    if (s == 0 && !bus.mem_ready) e = e & 16'h7BFF;
    chk($sformatf("state@%0t", $time), {28'd0, bus.state}, s);
    chk($sformatf("ctl_s%0d@%0t", s, $time), {16'd0, ctl_vec}, {16'd0, e});
    chk($sformatf("done_s%0d@%0t", s, $time), {31'd0, bus.instr_done}, {31'd0, done});
    tick();
  endtask

  int base;

  initial begin
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b1;
    #3;
    chk("rst_state", {28'd0, bus.state}, 0);
    chk("rst_retired", bus.retired_count, 0);
    chk("rst_ctl_rdy", {16'd0, ctl_vec}, 32'h9410);
    bus.mem_ready = 1'b0;
    #1;
    chk("rst_ctl_stall", {16'd0, ctl_vec}, 32'h1010);
    bus.mem_ready = 1'b1;
    tick();
    rst = 1'b0;

    // R-type, no stalls: 0,1,6,7
    bus.opcode = 6'b000000;
    step(0, 0); step(1, 0); step(6, 0); step(7, 1);
    chk("r_retired", bus.retired_count, 1);

    // lw with three stall cycles in MEM_READ: 8 cycles
    bus.opcode = 6'b100011;
    step(0, 0); step(1, 0); step(2, 0);
    bus.mem_ready = 1'b0;
    step(3, 0); step(3, 0); step(3, 0);
    bus.mem_ready = 1'b1;
    step(3, 0); step(4, 1);
    chk("lw_retired", bus.retired_count, 2);

    // sw, beq, j, addi back-to-back: 14 cycles
    base = 2;
    bus.opcode = 6'b101011;
    step(0, 0); step(1, 0); step(2, 0); step(5, 1);
    bus.opcode = 6'b000100;
    step(0, 0); step(1, 0); step(8, 1);
    bus.opcode = 6'b000010;
    step(0, 0); step(1, 0); step(9, 1);
    bus.opcode = 6'b001000;
    step(0, 0); step(1, 0); step(10, 0); step(11, 1);
    chk("mix_retired", bus.retired_count, base + 4);

    // FETCH stall: no IR/PC load until ready
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b0;
    step(0, 0); step(0, 0);
    bus.mem_ready = 1'b1;
    step(0, 0); step(1, 0); step(6, 0); step(7, 1);
    chk("fstall_retired", bus.retired_count, 7);

    // Async reset in the middle of a stalled store
    bus.opcode = 6'b101011;
    step(0, 0); step(1, 0); step(2, 0);
    bus.mem_ready = 1'b0;
    step(5, 0);
    chk("sw_hold_mw", {31'd0, bus.mem_write}, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", {28'd0, bus.state}, 0);
    chk("arst_mw", {31'd0, bus.mem_write}, 0);
    chk("arst_rw", {31'd0, bus.reg_write}, 0);
    chk("arst_retired", bus.retired_count, 0);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_state", {28'd0, bus.state}, 0);
    bus.mem_ready = 1'b1;

    // Unknown opcode
    bus.opcode = 6'b111111;
    step(0, 0);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    step(1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("trap_ill", {31'd0, bus.illegal_op}, 1);
      step(12, 0);
    end
    chk("trap_retired", bus.retired_count, 0);
`else
    step(1, 1);
    chk("nop_retired", bus.retired_count, 1);
    step(0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
